// File: rtl/neuron_emit_arb_if.sv
// rtl/neuron_emit_arb_if.sv - source and output-queue handshake bundle for neuron_emit_arb
interface neuron_emit_arb_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_ready;
  logic                 emit_valid;
  logic [7:0]           emit_data;
  logic                 have_out;

  // Arbiter side: grants sources and drives the queue input
  modport master (
    input  src_valid, src_data, have_out,
    output src_ready, emit_valid, emit_data
  );

  // Environment side: neuron array plus output queue
  modport slave (
    output src_valid, src_data, have_out,
    input  src_ready, emit_valid, emit_data
  );
endinterface

// File: rtl/neuron_emit_arb.sv
// rtl/neuron_emit_arb.sv - round-robin arbiter feeding the single-entry neuron output queue
module neuron_emit_arb #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  neuron_emit_arb_if.master  bus,
  output logic               busy,
  output logic [SEL_W-1:0]   last_src,
  output logic [15:0]        evt_count
);

  localparam int IDX_W = SEL_W + 1;
  localparam logic [IDX_W-1:0] NUM_L = IDX_W'(NUM_SRC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   rr_ptr_q;
  logic [SEL_W-1:0]   last_src_q;
  logic [7:0]         hold_data_q;
  logic               emit_valid_q;
  logic               busy_q;
  logic [15:0]        evt_count_q;

  logic               found_d;
  logic               accept_d;
  logic [SEL_W-1:0]   sel_d;
  logic [SEL_W-1:0]   rr_ptr_d;
  logic [IDX_W-1:0]   idx_d;
  logic [IDX_W-1:0]   nxt_d;
  logic [NUM_SRC-1:0] ready_d;

  // Find the first valid source starting at rr_ptr and wrapping modulo NUM_SRC
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    idx_d   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx_d = {1'b0, rr_ptr_q} + IDX_W'(k);
      if (idx_d >= NUM_L) begin
        idx_d = idx_d - NUM_L;
      end
      if (!found_d && bus.src_valid[idx_d[SEL_W-1:0]]) begin
        found_d = 1'b1;
        sel_d   = idx_d[SEL_W-1:0];
      end
    end
  end

  // Accept only from IDLE with the queue slot drained; grant is a same-cycle one-hot
  always_comb begin
    accept_d = rst_n && ena && (state_q == IDLE) && !bus.have_out && found_d;
    ready_d  = '0;
    if (accept_d) begin
      ready_d[sel_d] = 1'b1;
    end
    nxt_d    = {1'b0, sel_d} + IDX_W'(1);
    rr_ptr_d = (nxt_d == NUM_L) ? '0 : nxt_d[SEL_W-1:0];
  end

  // Arbiter FSM; ena low behaves like reset so a held event is simply dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      last_src_q   <= '0;
      hold_data_q  <= '0;
      emit_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      evt_count_q  <= '0;
    end else if (!ena) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      last_src_q   <= '0;
      hold_data_q  <= '0;
      emit_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      evt_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            hold_data_q  <= bus.src_data[{sel_d, 3'b000} +: 8];
            last_src_q   <= sel_d;
            rr_ptr_q     <= rr_ptr_d;
            emit_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          // A foreign fill keeps the event parked with stable data
          if (!bus.have_out) begin
            hold_data_q  <= '0;
            emit_valid_q <= 1'b0;
            if (evt_count_q != 16'hFFFF) begin
              evt_count_q <= evt_count_q + 16'd1;
            end
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!bus.have_out) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.src_ready  = ready_d;
  assign bus.emit_valid = emit_valid_q;
  assign bus.emit_data  = hold_data_q;
  assign busy           = busy_q;
  assign last_src       = last_src_q;
  assign evt_count      = evt_count_q;

endmodule
